cpu_clk_ctrl: RTL and testbench

CPU_CLK_CTRL -- requirements
Module: cpu_clk_ctrl

---
 rtl/cpu_clk_ctrl.sv | 142 ++++++++++++++
 tb/tb_cpu_clk_ctrl.sv | 254 +++++++++++++++++++++++++
 2 files changed

// File: rtl/cpu_clk_ctrl.sv
// cpu_clk_ctrl: generates the CPU clock-enable for a single-stepping debug
// front panel. Free-run mode divides clk by FAST_DIV or SLOW_DIV; step mode
// issues one enable per (debounced) button press; a breakpoint from the CPU
// drops free-run into a sticky halted state until run_sw is cycled.
module cpu_clk_ctrl #(
  parameter int unsigned FAST_DIV = 16,
  parameter int unsigned SLOW_DIV = 33554432
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        run_sw,
  input  logic        step_btn,
  input  logic        speed_sel,
  input  logic        bp_hit,
  input  logic        clr_cnt,
  output logic        cpu_ce,
  output logic [1:0]  state,
  output logic        bp_halted,
  output logic [31:0] cycle_cnt
);

  typedef enum logic [1:0] {
    HALT     = 2'b00,
    RUN      = 2'b01,
    STEP     = 2'b10,
    WAIT_REL = 2'b11
  } state_t;

  // Terminal divider values; tick fires once div_cnt reaches N-1.
  localparam logic [31:0] FAST_LAST = 32'(FAST_DIV - 32'd1);
  localparam logic [31:0] SLOW_LAST = 32'(SLOW_DIV - 32'd1);

  state_t      state_q, state_d;
  logic        s1_q, s1_d;
  logic        s2_q, s2_d;
  logic        s3_q, s3_d;
  logic [31:0] div_cnt_q, div_cnt_d;
  logic        cpu_ce_q, cpu_ce_d;
  logic        bp_halted_q, bp_halted_d;
  logic [31:0] cycle_cnt_q, cycle_cnt_d;

  logic        step_rise;
  logic [31:0] div_last;
  logic        tick;

  // Next-state logic for the synchroniser, FSM, divider, enable and counter.
  always_comb begin
    // step_btn is asynchronous: two flops for metastability, a third for edge detect
    s1_d      = step_btn;
    s2_d      = s1_q;
    s3_d      = s2_q;
    step_rise = s2_q & ~s3_q;

    // speed_sel is not latched, so a mid-run change applies on the very next compare;
    // >= (rather than ==) makes an overshot count tick immediately
    div_last  = speed_sel ? SLOW_LAST : FAST_LAST;
    tick      = (div_cnt_q >= div_last);

    state_d = state_q;
    unique case (state_q)
      HALT: begin
        if (run_sw && !bp_halted_q) begin
          state_d = RUN;
        end else if (step_rise) begin
          state_d = STEP;
        end
      end
      RUN: begin
        if (bp_hit || !run_sw) begin
          state_d = HALT;
        end
      end
      STEP: begin
        state_d = WAIT_REL;
      end
      WAIT_REL: begin
        // hold here until the button is released so a long press is one step
        if (!s2_q) begin
          state_d = HALT;
        end
      end
      default: begin
        state_d = HALT;
      end
    endcase

    // divider only counts while staying in RUN; anywhere else it parks at 0,
    // which guarantees a fresh count on every RUN entry
    div_cnt_d = 32'd0;
    if (state_q == RUN && state_d == RUN && !tick) begin
      div_cnt_d = div_cnt_q + 32'd1;
    end

    // a breakpoint or a dropped run switch on the tick cycle suppresses that pulse
    cpu_ce_d = ((state_q == RUN) && tick && !bp_hit && run_sw) || (state_q == STEP);

    // set beats clear, so bp_hit together with run_sw falling still leaves the
    // flag up for one cycle before run_sw=0 clears it
    bp_halted_d = bp_halted_q;
    if (state_q == RUN && bp_hit) begin
      bp_halted_d = 1'b1;
    end else if (!run_sw || step_rise) begin
      bp_halted_d = 1'b0;
    end

    // counts pulses already presented on cpu_ce; clear has priority
    if (clr_cnt) begin
      cycle_cnt_d = 32'd0;
    end else begin
      cycle_cnt_d = cycle_cnt_q + {31'd0, cpu_ce_q};
    end
  end

  // State registers with asynchronous active-low reset; reset also kills any pending pulse.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= HALT;
      s1_q        <= 1'b0;
      s2_q        <= 1'b0;
      s3_q        <= 1'b0;
      div_cnt_q   <= 32'd0;
      cpu_ce_q    <= 1'b0;
      bp_halted_q <= 1'b0;
      cycle_cnt_q <= 32'd0;
    end else begin
      state_q     <= state_d;
      s1_q        <= s1_d;
      s2_q        <= s2_d;
      s3_q        <= s3_d;
      div_cnt_q   <= div_cnt_d;
      cpu_ce_q    <= cpu_ce_d;
      bp_halted_q <= bp_halted_d;
      cycle_cnt_q <= cycle_cnt_d;
    end
  end

  assign cpu_ce    = cpu_ce_q;
  assign state     = state_q;
  assign bp_halted = bp_halted_q;
  assign cycle_cnt = cycle_cnt_q;

endmodule

// File: tb/tb_cpu_clk_ctrl.sv
// tb_cpu_clk_ctrl: directed bench for cpu_clk_ctrl (FAST_DIV=4, SLOW_DIV=64).
// Stimulus pushes the clk-edge index after which each cpu_ce pulse must be
// visible; a negedge monitor pops one entry per observed pulse.
module tb_cpu_clk_ctrl;

  localparam logic [1:0] S_HALT = 2'b00;
  localparam logic [1:0] S_RUN  = 2'b01;
  localparam logic [1:0] S_STEP = 2'b10;
  localparam logic [1:0] S_WAIT = 2'b11;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        run_sw = 1'b0;
  logic        step_btn = 1'b0;
  logic        speed_sel = 1'b0;
  logic        bp_hit = 1'b0;
  logic        clr_cnt = 1'b0;
  logic        cpu_ce;
  logic [1:0]  state;
  logic        bp_halted;
  logic [31:0] cycle_cnt;

  int checks = 0;
  int failures = 0;
  int cyc = 0;        // number of rising edges so far
  int exp_q[$];       // edge index after which a cpu_ce pulse is expected
  int exp_pulse;

  cpu_clk_ctrl #(.FAST_DIV(4), .SLOW_DIV(64)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .run_sw    (run_sw),
    .step_btn  (step_btn),
    .speed_sel (speed_sel),
    .bp_hit    (bp_hit),
    .clr_cnt   (clr_cnt),
    .cpu_ce    (cpu_ce),
    .state     (state),
    .bp_halted (bp_halted),
    .cycle_cnt (cycle_cnt)
  );

  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got 0x%08h, expected 0x%08h (edge %0d)", name, act, exp, cyc);
    end
  endtask

  task automatic wait_to(input int n);
    while (cyc < n) @(negedge clk);
  endtask

  // One step press held until the pulse, optionally with clr_cnt on the pulse cycle.
  task automatic do_step(input logic clr_at_pulse);
    int e0;
    step_btn = 1'b1;
    e0 = cyc + 1;
    exp_q.push_back(e0 + 3);
    wait_to(e0 + 3);
    clr_cnt = clr_at_pulse;
    wait_to(e0 + 4);
    clr_cnt  = 1'b0;
    step_btn = 1'b0;
    wait_to(e0 + 7);
    chk("step_back_to_halt", {30'd0, state}, {30'd0, S_HALT});
  endtask

  // Pulse monitor
  always @(negedge clk) begin
    if (cpu_ce !== 1'b0) begin
      checks++;
      if (exp_q.size() == 0) begin
        failures++;
        $display("FAIL pulse_unexpected: cpu_ce=%b after edge %0d, no pulse expected", cpu_ce, cyc);
      end else begin
        exp_pulse = exp_q.pop_front();
        if (exp_pulse != cyc) begin
          failures++;
          $display("FAIL pulse_timing: cpu_ce after edge %0d, expected after edge %0d", cyc, exp_pulse);
        end
      end
    end
  end

  initial begin
    #100000;
    $display("FAIL watchdog: simulation exceeded time limit at edge %0d", cyc);
    $fatal(1, "watchdog");
  end

  initial begin
    int x;
    int y;
    int c;

    // Reset state
    rst_n = 1'b1;
    #2 rst_n = 1'b0;
    @(negedge clk);
    @(negedge clk);
    chk("rst_state", {30'd0, state}, {30'd0, S_HALT});
    chk("rst_cpu_ce", {31'd0, cpu_ce}, 32'd0);
    chk("rst_bp_halted", {31'd0, bp_halted}, 32'd0);
    chk("rst_cycle_cnt", cycle_cnt, 32'd0);
    rst_n = 1'b1;
    @(negedge clk);

    // Free-run at FAST_DIV=4 for 20 cycles: pulses 4,8,...,20 after entry
    run_sw = 1'b1;
    x = cyc + 1;
    for (int k = 1; k <= 5; k++) exp_q.push_back(x + 4 * k);
    wait_to(x + 2);
    chk("run_state", {30'd0, state}, {30'd0, S_RUN});
    wait_to(x + 20);
    run_sw = 1'b0;
    wait_to(x + 21);
    chk("run_stop_state", {30'd0, state}, {30'd0, S_HALT});
    chk("run_cycle_cnt", cycle_cnt, 32'd5);

    // Step button held 50 cycles: one pulse at E0+3, HALT 2 edges after release
    step_btn = 1'b1;
    x = cyc + 1;
    exp_q.push_back(x + 3);
    wait_to(x + 1);
    chk("step_sync_halt", {30'd0, state}, {30'd0, S_HALT});
    wait_to(x + 2);
    chk("step_state", {30'd0, state}, {30'd0, S_STEP});
    wait_to(x + 3);
    chk("step_wait_rel", {30'd0, state}, {30'd0, S_WAIT});
    wait_to(x + 48);
    chk("step_held", {30'd0, state}, {30'd0, S_WAIT});
    wait_to(x + 49);
    step_btn = 1'b0;
    y = x + 50;
    wait_to(y + 1);
    chk("step_rel_wait", {30'd0, state}, {30'd0, S_WAIT});
    wait_to(y + 2);
    chk("step_rel_halt", {30'd0, state}, {30'd0, S_HALT});
    chk("step_cycle_cnt", cycle_cnt, 32'd6);

    // Breakpoint on a tick cycle: pulse suppressed, sticky halt until run_sw cycles
    run_sw = 1'b1;
    x = cyc + 1;
    exp_q.push_back(x + 4);
    wait_to(x + 7);
    bp_hit = 1'b1;
    wait_to(x + 8);
    bp_hit = 1'b0;
    chk("bp_state", {30'd0, state}, {30'd0, S_HALT});
    chk("bp_halted_set", {31'd0, bp_halted}, 32'd1);
    chk("bp_no_ce", {31'd0, cpu_ce}, 32'd0);
    wait_to(x + 13);
    chk("bp_stays_halted", {30'd0, state}, {30'd0, S_HALT});
    chk("bp_still_sticky", {31'd0, bp_halted}, 32'd1);
    run_sw = 1'b0;
    wait_to(x + 14);
    chk("bp_cleared", {31'd0, bp_halted}, 32'd0);
    run_sw = 1'b1;
    y = x + 15;
    exp_q.push_back(y + 4);
    wait_to(y + 1);
    chk("bp_resume_run", {30'd0, state}, {30'd0, S_RUN});
    wait_to(y + 4);
    run_sw = 1'b0;
    wait_to(y + 5);
    chk("bp_resume_cnt", cycle_cnt, 32'd8);

    // bp_hit outside RUN is ignored
    c = cyc;
    bp_hit = 1'b1;
    wait_to(c + 1);
    bp_hit = 1'b0;
    wait_to(c + 2);
    chk("bp_ignored_halt", {31'd0, bp_halted}, 32'd0);

    // bp_hit and run_sw falling together: halted flag set, cleared next cycle
    run_sw = 1'b1;
    x = cyc + 1;
    wait_to(x + 1);
    bp_hit = 1'b1;
    run_sw = 1'b0;
    wait_to(x + 2);
    bp_hit = 1'b0;
    chk("bp_runfall_state", {30'd0, state}, {30'd0, S_HALT});
    chk("bp_runfall_set", {31'd0, bp_halted}, 32'd1);
    wait_to(x + 3);
    chk("bp_runfall_clear", {31'd0, bp_halted}, 32'd0);

    // Counter wrap: preload 0xFFFFFFFF, one step wraps to 0
    force dut.cycle_cnt_d = 32'hFFFF_FFFF;
    @(posedge clk);
    #1 release dut.cycle_cnt_d;
    @(negedge clk);
    chk("cnt_preload", cycle_cnt, 32'hFFFF_FFFF);
    do_step(1'b0);
    chk("cnt_wrap", cycle_cnt, 32'd0);

    // clr_cnt coincident with cpu_ce: clear wins
    do_step(1'b0);
    chk("cnt_step_one", cycle_cnt, 32'd1);
    do_step(1'b1);
    chk("cnt_clr_wins", cycle_cnt, 32'd0);

    // Speed switch mid-run: slow count reaches 30, switch to fast -> tick next cycle
    speed_sel = 1'b1;
    run_sw = 1'b1;
    x = cyc + 1;
    exp_q.push_back(x + 31);
    exp_q.push_back(x + 35);
    exp_q.push_back(x + 39);
    wait_to(x + 30);
    speed_sel = 1'b0;
    wait_to(x + 39);
    run_sw = 1'b0;
    wait_to(x + 40);
    chk("speed_halt", {30'd0, state}, {30'd0, S_HALT});
    chk("speed_cnt", cycle_cnt, 32'd3);

    // Reset the cycle before a pending pulse: pulse aborted, outputs at reset values
    run_sw = 1'b1;
    x = cyc + 1;
    wait_to(x + 3);
    chk("rst_mid_run_state", {30'd0, state}, {30'd0, S_RUN});
    rst_n = 1'b0;
    run_sw = 1'b0;
    #1;
    chk("rst_mid_state", {30'd0, state}, {30'd0, S_HALT});
    chk("rst_mid_ce", {31'd0, cpu_ce}, 32'd0);
    chk("rst_mid_bp", {31'd0, bp_halted}, 32'd0);
    chk("rst_mid_cnt", cycle_cnt, 32'd0);
    wait_to(x + 6);
    rst_n = 1'b1;
    wait_to(x + 12);
    chk("rst_after_state", {30'd0, state}, {30'd0, S_HALT});
    chk("rst_after_cnt", cycle_cnt, 32'd0);

    // Every expected pulse must have been observed
    checks++;
    if (exp_q.size() != 0) begin
      failures++;
      $display("FAIL pulse_missing: %0d expected pulses not seen, expected 0", exp_q.size());
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
